axil_read_arbiter: RTL and testbench

- Shares one AXI4-Lite read channel (AR and R) between two requesters.
- Port 0 is instruction fetch (the output of the fetch skid buffer). Port 1 is the load/store unit.
- Sits between the core and the unified memory/interconnect.
- Allows one outstanding transaction at a time, uses round-robin arbitration, and routes each R response back to the requester that issued it.

---
 rtl/axil_read_arbiter_pkg.sv | 14 +
 rtl/axil_read_arbiter_rr_arbiter2.sv | 27 ++
 rtl/axil_read_arbiter.sv | 134 +++++++++++++
 tb/tb_axil_read_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_read_arbiter_pkg.sv
// Shared types and constants for the two-port AXI4-Lite read arbiter.
// Requesters tag their reads with the ArProt* encodings.
package axil_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbAddr = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

  localparam logic [2:0] ArProtInstr = 3'b100;
  localparam logic [2:0] ArProtData  = 3'b000;

endpackage

// File: rtl/axil_read_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. It is purely combinational; the caller keeps
// the last_grant register and only enables the picker when it can accept.
module rr_arbiter2
  import axil_read_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // On a tie the port that did not win last time goes next.
  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
    gnt = 2'b00;
    if (en && (req != 2'b00)) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// Shares one AXI4-Lite read channel between instruction fetch (port 0) and
// the load/store unit (port 1), one transaction in flight at a time.
module axil_read_arbiter
  import axil_read_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            i_s0_arvalid,
  output logic            o_s0_arready,
  input  logic [XLEN-1:0] i_s0_araddr,
  input  logic [2:0]      i_s0_arprot,
  output logic            o_s0_rvalid,
  input  logic            i_s0_rready,
  output logic [XLEN-1:0] o_s0_rdata,
  output logic [1:0]      o_s0_rresp,

  input  logic            i_s1_arvalid,
  output logic            o_s1_arready,
  input  logic [XLEN-1:0] i_s1_araddr,
  input  logic [2:0]      i_s1_arprot,
  output logic            o_s1_rvalid,
  input  logic            i_s1_rready,
  output logic [XLEN-1:0] o_s1_rdata,
  output logic [1:0]      o_s1_rresp,

  output logic            o_m_arvalid,
  input  logic            i_m_arready,
  output logic [XLEN-1:0] o_m_araddr,
  output logic [2:0]      o_m_arprot,
  input  logic            i_m_rvalid,
  output logic            o_m_rready,
  input  logic [XLEN-1:0] i_m_rdata,
  input  logic [1:0]      i_m_rresp,

  output logic            o_grant,
  output logic            o_busy
);

  arb_state_e      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      prot_q, prot_d;
  logic            grant_q, grant_d;

  logic            in_idle;
  logic            in_resp;
  logic [1:0]      arb_gnt;
  logic            arb_idx;
  logic            sel_rready;
  logic            m_rready;

  assign in_idle = (state_q == ArbIdle);
  assign in_resp = (state_q == ArbResp);

  rr_arbiter2 u_rr_arbiter2 (
    .req        ({i_s1_arvalid, i_s0_arvalid}),
    .last_grant (last_grant_q),
    .en         (in_idle),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign sel_rready = grant_q ? i_s1_rready : i_s0_rready;
  assign m_rready   = in_resp && sel_rready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    prot_d       = prot_q;
    grant_d      = grant_q;
    case (state_q)
      ArbIdle: begin
        if (arb_gnt != 2'b00) begin
          state_d      = ArbAddr;
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          addr_d       = arb_idx ? i_s1_araddr : i_s0_araddr;
          prot_d       = arb_idx ? i_s1_arprot : i_s0_arprot;
        end
      end
      ArbAddr: begin
        if (i_m_arready) begin
          state_d = ArbResp;
        end
      end
      ArbResp: begin
        if (i_m_rvalid && m_rready) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // last_grant resets to the LSU so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ArbIdle;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      prot_q       <= '0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      prot_q       <= prot_d;
      grant_q      <= grant_d;
    end
  end

  assign o_s0_arready = arb_gnt[0];
  assign o_s1_arready = arb_gnt[1];

  assign o_m_arvalid  = (state_q == ArbAddr);
  assign o_m_araddr   = addr_q;
  assign o_m_arprot   = prot_q;
  assign o_m_rready   = m_rready;

  assign o_s0_rvalid  = in_resp && !grant_q && i_m_rvalid;
  assign o_s1_rvalid  = in_resp &&  grant_q && i_m_rvalid;
  assign o_s0_rdata   = i_m_rdata;
  assign o_s1_rdata   = i_m_rdata;
  assign o_s0_rresp   = i_m_rresp;
  assign o_s1_rresp   = i_m_rresp;

  assign o_busy       = !in_idle;
  assign o_grant      = grant_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed checks of the arbiter handshakes followed by a randomized run
// scored against a transaction-level model of the shared read channel.
module tb_axil_read_arbiter;
  import axil_read_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            i_s0_arvalid, o_s0_arready, o_s0_rvalid, i_s0_rready;
  logic [XLEN-1:0] i_s0_araddr, o_s0_rdata;
  logic [2:0]      i_s0_arprot;
  logic [1:0]      o_s0_rresp;
  logic            i_s1_arvalid, o_s1_arready, o_s1_rvalid, i_s1_rready;
  logic [XLEN-1:0] i_s1_araddr, o_s1_rdata;
  logic [2:0]      i_s1_arprot;
  logic [1:0]      o_s1_rresp;
  logic            o_m_arvalid, i_m_arready, i_m_rvalid, o_m_rready;
  logic [XLEN-1:0] o_m_araddr, i_m_rdata;
  logic [2:0]      o_m_arprot;
  logic [1:0]      i_m_rresp;
  logic            o_grant, o_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  axil_read_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .i_s0_arvalid(i_s0_arvalid), .o_s0_arready(o_s0_arready),
    .i_s0_araddr(i_s0_araddr), .i_s0_arprot(i_s0_arprot),
    .o_s0_rvalid(o_s0_rvalid), .i_s0_rready(i_s0_rready),
    .o_s0_rdata(o_s0_rdata), .o_s0_rresp(o_s0_rresp),
    .i_s1_arvalid(i_s1_arvalid), .o_s1_arready(o_s1_arready),
    .i_s1_araddr(i_s1_araddr), .i_s1_arprot(i_s1_arprot),
    .o_s1_rvalid(o_s1_rvalid), .i_s1_rready(i_s1_rready),
    .o_s1_rdata(o_s1_rdata), .o_s1_rresp(o_s1_rresp),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready),
    .o_m_araddr(o_m_araddr), .o_m_arprot(o_m_arprot),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic applyStimulus(input logic s0v, input logic [31:0] s0a,
                               input logic s1v, input logic [31:0] s1a,
                               input logic m_ar_rdy, input logic m_rv,
                               input logic [31:0] m_rd, input logic [1:0] m_rr,
                               input logic s0_rr, input logic s1_rr);
    @(negedge clk);
    i_s0_arvalid = s0v;  i_s0_araddr = s0a;  i_s0_arprot = ArProtInstr;
    i_s1_arvalid = s1v;  i_s1_araddr = s1a;  i_s1_arprot = ArProtData;
    i_m_arready  = m_ar_rdy;
    i_m_rvalid   = m_rv;  i_m_rdata = m_rd;  i_m_rresp = m_rr;
    i_s0_rready  = s0_rr; i_s1_rready = s1_rr;
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rstn = 1'b0;
    i_s0_arvalid = 1'b0; i_s0_araddr = '0; i_s0_arprot = '0;
    i_s1_arvalid = 1'b0; i_s1_araddr = '0; i_s1_arprot = '0;
    i_m_arready = 1'b0; i_m_rdata = 32'hDEAD_BEEF; i_m_rresp = 2'b00;
    i_m_rvalid = 1'b1; i_s0_rready = 1'b1; i_s1_rready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Transaction-level model state for the randomized run.
  bit          r_act [2];
  bit          r_wait[2];
  logic [31:0] r_addr[2];
  logic [2:0]  r_prot[2];
  bit          inflight, ar_sent, owner, model_last, model_grant, mem_pending;
  int          mem_delay;
  logic [31:0] cur_addr;
  logic [2:0]  cur_prot;
  logic [1:0]  cur_resp;
  int          done_cnt[2];
  int          ar_hs_count;

  initial begin
    rstn = 1'b0;

    // Reset state
    resetDut();
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_grant", o_grant, 0);
    checkOutput("rst_m_arvalid", o_m_arvalid, 0);
    checkOutput("rst_m_araddr", o_m_araddr, 0);
    checkOutput("rst_m_arprot", o_m_arprot, 0);
    checkOutput("rst_m_rready", o_m_rready, 0);
    checkOutput("rst_s0_rvalid", o_s0_rvalid, 0);
    checkOutput("rst_s1_rvalid", o_s1_rvalid, 0);

    // Fetch only, zero-wait memory
    applyStimulus(1, 32'h0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("f_c0_s0_arready", o_s0_arready, 1);
    checkOutput("f_c0_s1_arready", o_s1_arready, 0);
    checkOutput("f_c0_m_arvalid", o_m_arvalid, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("f_c1_m_arvalid", o_m_arvalid, 1);
    checkOutput("f_c1_m_araddr", o_m_araddr, 32'h0);
    checkOutput("f_c1_m_arprot", o_m_arprot, ArProtInstr);
    checkOutput("f_c1_busy", o_busy, 1);
    checkOutput("f_c1_s0_arready", o_s0_arready, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 32'h13, 2'b00, 1, 1);
    checkOutput("f_c2_s0_rvalid", o_s0_rvalid, 1);
    checkOutput("f_c2_s0_rdata", o_s0_rdata, 32'h13);
    checkOutput("f_c2_s0_rresp", o_s0_rresp, 2'b00);
    checkOutput("f_c2_s1_rvalid", o_s1_rvalid, 0);
    checkOutput("f_c2_m_rready", o_m_rready, 1);
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("f_c3_busy", o_busy, 0);
    checkOutput("f_c3_s1_rvalid", o_s1_rvalid, 0);

    // Simultaneous requests after reset: grant order 0,1,0
    resetDut();
    applyStimulus(1, 32'h100, 1, 32'h2000, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c0_s0_arready", o_s0_arready, 1);
    checkOutput("rr_c0_s1_arready", o_s1_arready, 0);
    applyStimulus(1, 32'h104, 1, 32'h2000, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c1_grant", o_grant, 0);
    checkOutput("rr_c1_m_araddr", o_m_araddr, 32'h100);
    checkOutput("rr_c1_s1_arready", o_s1_arready, 0);
    applyStimulus(1, 32'h104, 1, 32'h2000, 1, 1, 32'hAAAA_0100, 2'b00, 1, 1);
    checkOutput("rr_c2_s0_rvalid", o_s0_rvalid, 1);
    checkOutput("rr_c2_s1_rvalid", o_s1_rvalid, 0);
    applyStimulus(1, 32'h104, 1, 32'h2000, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c3_s1_arready", o_s1_arready, 1);
    checkOutput("rr_c3_s0_arready", o_s0_arready, 0);
    applyStimulus(1, 32'h104, 1, 32'h2004, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c4_grant", o_grant, 1);
    checkOutput("rr_c4_m_araddr", o_m_araddr, 32'h2000);
    checkOutput("rr_c4_m_arprot", o_m_arprot, ArProtData);
    applyStimulus(1, 32'h104, 1, 32'h2004, 1, 1, 32'hBBBB_2000, 2'b00, 1, 1);
    checkOutput("rr_c5_s1_rvalid", o_s1_rvalid, 1);
    checkOutput("rr_c5_s0_rvalid", o_s0_rvalid, 0);
    checkOutput("rr_c5_s1_rdata", o_s1_rdata, 32'hBBBB_2000);
    applyStimulus(1, 32'h104, 1, 32'h2004, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c6_s0_arready", o_s0_arready, 1);
    checkOutput("rr_c6_s1_arready", o_s1_arready, 0);
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rr_c7_grant", o_grant, 0);
    checkOutput("rr_c7_m_araddr", o_m_araddr, 32'h104);
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 32'hCCCC_0104, 2'b00, 1, 1);
    checkOutput("rr_c8_s0_rvalid", o_s0_rvalid, 1);

    // Memory stalls AR for 4 cycles
    resetDut();
    ar_hs_count = 0;
    applyStimulus(0, 32'h0, 1, 32'h40, 0, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("st_c0_s1_arready", o_s1_arready, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h80, 0, 32'h0, 0, 0, 32'h0, 2'b00, 1, 1);
      checkOutput("st_hold_m_arvalid", o_m_arvalid, 1);
      checkOutput("st_hold_m_araddr", o_m_araddr, 32'h40);
      checkOutput("st_hold_s0_arready", o_s0_arready, 0);
      checkOutput("st_hold_s1_arready", o_s1_arready, 0);
      if (o_m_arvalid && i_m_arready) ar_hs_count++;
    end
    applyStimulus(1, 32'h80, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("st_c5_m_arvalid", o_m_arvalid, 1);
    if (o_m_arvalid && i_m_arready) ar_hs_count++;
    applyStimulus(1, 32'h80, 0, 32'h0, 1, 1, 32'h1234_0040, 2'b00, 1, 1);
    checkOutput("st_c6_m_arvalid", o_m_arvalid, 0);
    checkOutput("st_c6_s1_rvalid", o_s1_rvalid, 1);
    if (o_m_arvalid && i_m_arready) ar_hs_count++;
    applyStimulus(1, 32'h80, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("st_c7_s0_arready", o_s0_arready, 1);
    if (o_m_arvalid && i_m_arready) ar_hs_count++;
    checkOutput("st_ar_handshakes", ar_hs_count, 1);

    // LSU response backpressure with SLVERR, then reset during ADDR
    resetDut();
    applyStimulus(0, 32'h0, 1, 32'h300, 1, 0, 32'h0, 2'b00, 1, 0);
    checkOutput("bp_c0_s1_arready", o_s1_arready, 1);
    applyStimulus(1, 32'h500, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 0);
    checkOutput("bp_c1_m_arvalid", o_m_arvalid, 1);
    checkOutput("bp_c1_s0_arready", o_s0_arready, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h500, 0, 32'h0, 1, 1, 32'hCAFE_0300, 2'b10, 1, 0);
      checkOutput("bp_stall_s1_rvalid", o_s1_rvalid, 1);
      checkOutput("bp_stall_m_rready", o_m_rready, 0);
      checkOutput("bp_stall_busy", o_busy, 1);
      checkOutput("bp_stall_s0_arready", o_s0_arready, 0);
      checkOutput("bp_stall_s1_rresp", o_s1_rresp, 2'b10);
    end
    applyStimulus(1, 32'h500, 0, 32'h0, 1, 1, 32'hCAFE_0300, 2'b10, 1, 1);
    checkOutput("bp_c5_m_rready", o_m_rready, 1);
    checkOutput("bp_c5_s0_arready", o_s0_arready, 0);
    checkOutput("bp_c5_s1_rdata", o_s1_rdata, 32'hCAFE_0300);
    checkOutput("bp_c5_s1_rresp", o_s1_rresp, 2'b10);
    applyStimulus(1, 32'h500, 0, 32'h0, 1, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("bp_c6_busy", o_busy, 0);
    checkOutput("bp_c6_s0_arready", o_s0_arready, 1);
    applyStimulus(1, 32'h504, 1, 32'h600, 0, 0, 32'h0, 2'b00, 1, 1);
    checkOutput("rs_c7_m_arvalid", o_m_arvalid, 1);
    checkOutput("rs_c7_m_araddr", o_m_araddr, 32'h500);
    rstn = 1'b0;
    applyStimulus(1, 32'h504, 1, 32'h600, 0, 0, 32'h0, 2'b00, 1, 1);
    rstn = 1'b1;
    checkOutput("rs_c8_busy", o_busy, 0);
    checkOutput("rs_c8_m_arvalid", o_m_arvalid, 0);
    checkOutput("rs_c8_grant", o_grant, 0);
    checkOutput("rs_c8_tie_s0_arready", o_s0_arready, 1);
    checkOutput("rs_c8_tie_s1_arready", o_s1_arready, 0);

    // Randomized traffic against the transaction-level model
    resetDut();
    for (int p = 0; p < 2; p++) begin
      r_act[p] = 0; r_wait[p] = 0; r_addr[p] = '0; r_prot[p] = '0; done_cnt[p] = 0;
    end
    inflight = 0; ar_sent = 0; owner = 0; model_last = 1; model_grant = 0;
    mem_pending = 0; mem_delay = 0; cur_addr = '0; cur_prot = '0; cur_resp = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      bit          exp_any, win, exp_ar0, exp_ar1, exp_m_arvalid;
      bit          exp_rv0, exp_rv1, exp_m_rready, ar_hs, m_ar_hs, r_hs;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!r_act[p] && !r_wait[p] && $urandom_range(0, 2) != 0) begin
          r_act[p]  = 1;
          r_addr[p] = $urandom & 32'hFFFF_FFFC;
          r_prot[p] = 3'($urandom_range(0, 7));
        end
      end
      i_s0_arvalid = r_act[0]; i_s0_araddr = r_addr[0]; i_s0_arprot = r_prot[0];
      i_s1_arvalid = r_act[1]; i_s1_araddr = r_addr[1]; i_s1_arprot = r_prot[1];
      i_s0_rready  = ($urandom_range(0, 3) != 0);
      i_s1_rready  = ($urandom_range(0, 3) != 0);
      i_m_arready  = 1'($urandom_range(0, 1));
      i_m_rvalid   = mem_pending && (mem_delay == 0);
      i_m_rdata    = mem_pending ? memWord(cur_addr) : $urandom;
      i_m_rresp    = mem_pending ? cur_resp : 2'b00;
      #1;

      exp_any       = !inflight && (r_act[0] || r_act[1]);
      win           = (r_act[0] && r_act[1]) ? !model_last : r_act[1];
      exp_ar0       = exp_any && !win;
      exp_ar1       = exp_any && win;
      exp_m_arvalid = inflight && !ar_sent;
      exp_rv0       = inflight && ar_sent && !owner && i_m_rvalid;
      exp_rv1       = inflight && ar_sent &&  owner && i_m_rvalid;
      exp_m_rready  = inflight && ar_sent && (owner ? i_s1_rready : i_s0_rready);

      checkOutput("rnd_s0_arready", o_s0_arready, exp_ar0);
      checkOutput("rnd_s1_arready", o_s1_arready, exp_ar1);
      checkOutput("rnd_m_arvalid", o_m_arvalid, exp_m_arvalid);
      checkOutput("rnd_s0_rvalid", o_s0_rvalid, exp_rv0);
      checkOutput("rnd_s1_rvalid", o_s1_rvalid, exp_rv1);
      checkOutput("rnd_m_rready", o_m_rready, exp_m_rready);
      checkOutput("rnd_busy", o_busy, inflight);
      checkOutput("rnd_grant", o_grant, model_grant);
      if (exp_m_arvalid) begin
        checkOutput("rnd_m_araddr", o_m_araddr, cur_addr);
        checkOutput("rnd_m_arprot", o_m_arprot, cur_prot);
      end
      if (exp_rv0) begin
        checkOutput("rnd_s0_rdata", o_s0_rdata, memWord(cur_addr));
        checkOutput("rnd_s0_rresp", o_s0_rresp, cur_resp);
      end
      if (exp_rv1) begin
        checkOutput("rnd_s1_rdata", o_s1_rdata, memWord(cur_addr));
        checkOutput("rnd_s1_rresp", o_s1_rresp, cur_resp);
      end

      ar_hs   = exp_any;
      m_ar_hs = exp_m_arvalid && i_m_arready;
      r_hs    = i_m_rvalid && exp_m_rready;

      if (r_hs) begin
        inflight = 0; ar_sent = 0; mem_pending = 0;
        r_wait[owner] = 0;
        done_cnt[owner]++;
      end else if (mem_pending && mem_delay > 0) begin
        mem_delay--;
      end
      if (m_ar_hs) begin
        ar_sent     = 1;
        mem_pending = 1;
        mem_delay   = $urandom_range(0, 2);
        cur_resp    = 2'($urandom_range(0, 3));
      end
      if (ar_hs) begin
        inflight    = 1;
        owner       = win;
        model_last  = win;
        model_grant = win;
        cur_addr    = r_addr[win];
        cur_prot    = r_prot[win];
        r_act[win]  = 0;
        r_wait[win] = 1;
      end
    end
    checkOutput("rnd_s0_progress", done_cnt[0] > 5, 1);
    checkOutput("rnd_s1_progress", done_cnt[1] > 5, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
